// File: rtl/dp_iface_pkg.sv
// -----------------------------------------------------------------------------
// dp_iface_pkg
// Shared definitions for the switch/key datapath input interface:
//   - MODE_DATA / MODE_CTRL encodings of the sw_mode switch
//   - chunk_idx_w(): width of the chunk index, max(1, $clog2(n))
//   - default debounce and repeat periods for the 50 MHz board clock
// -----------------------------------------------------------------------------
package dp_iface_pkg;

   typedef enum logic {
      MODE_CTRL = 1'b0,
      MODE_DATA = 1'b1
   } mode_e;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
   localparam int REPEAT_CYCLES_DEFAULT   = 12500000;

   // A single-chunk word still needs a 1-bit index port.
   function automatic int chunk_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dp_input_iface_if.sv
// -----------------------------------------------------------------------------
// dp_input_iface_if
// Bundles the board-side inputs (raw key, mode switch, value switches) and the
// datapath-side outputs of dp_input_iface.
//   key_n       raw pushbutton, 0 = pressed
//   sw_mode     raw mode switch, 1 = data-load, 0 = control
//   sw_val      raw value switches (CTRL_W)
//   datapath_in assembled data word (DATA_W)
//   ctrl        latched control word (CTRL_W)
//   step        one-cycle datapath enable
//   chunk_idx   index of the next chunk to be written
//   led         status display (CTRL_W)
// Modports: slave = the interface block, master = the board / environment.
// -----------------------------------------------------------------------------
interface dp_input_iface_if #(
   parameter int DATA_W = 16,
   parameter int SW_W   = 8,
   parameter int CTRL_W = 9
);
   import dp_iface_pkg::*;

   localparam int CIDX_W = chunk_idx_w(DATA_W / SW_W);

   logic              key_n;
   logic              sw_mode;
   logic [CTRL_W-1:0] sw_val;
   logic [DATA_W-1:0] datapath_in;
   logic [CTRL_W-1:0] ctrl;
   logic              step;
   logic [CIDX_W-1:0] chunk_idx;
   logic [CTRL_W-1:0] led;

   modport slave (
      input  key_n, sw_mode, sw_val,
      output datapath_in, ctrl, step, chunk_idx, led
   );

   modport master (
      output key_n, sw_mode, sw_val,
      input  datapath_in, ctrl, step, chunk_idx, led
   );

endinterface

// File: rtl/dp_input_iface_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchroniser, stable-level counter and press pulse for one
// active-low pushbutton.
//   clk, rst_n  board clock, asynchronous active-low reset
//   key_n       raw pushbutton, 0 = pressed
//   press_evt   one-cycle pulse on the accepted released->pressed transition
//   key_level   debounced level, 1 = released
// A level is accepted only after DEBOUNCE_CYCLES consecutive cycles of the
// synced key differing from the current debounced level.
// -----------------------------------------------------------------------------
module key_debounce
   import dp_iface_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press_evt,
   output logic key_level
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic             key_sync_p0;
   logic             key_sync_p1;
   logic [CNT_W-1:0] stable_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_sync_p0 <= 1'b1;
         key_sync_p1 <= 1'b1;
         stable_cnt  <= '0;
         key_level   <= 1'b1;
         press_evt   <= 1'b0;
      end else begin
         // sync stage boundary: p0 metastability catcher, p1 usable level
         key_sync_p0 <= key_n;
         key_sync_p1 <= key_sync_p0;
         press_evt   <= 1'b0;
         if (key_sync_p1 != key_level) begin
            if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               key_level  <= key_sync_p1;
               stable_cnt <= '0;
               // only the move to pressed (0) is an event
               press_evt  <= ~key_sync_p1;
            end else begin
               stable_cnt <= stable_cnt + CNT_W'(1);
            end
         end else begin
            stable_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/dp_input_iface.sv
// -----------------------------------------------------------------------------
// dp_input_iface
// Turns one pushbutton and a bank of switches into a chunk-loaded data word,
// a latched control word and a one-cycle step enable for the datapath.
//   clk, rst_n  board clock, asynchronous active-low reset
//   bus         dp_input_iface_if.slave (key_n, sw_mode, sw_val in;
//               datapath_in, ctrl, step, chunk_idx, led out)
// Data mode:    each press writes sw_val[SW_W-1:0] into chunk chunk_idx.
// Control mode: each press latches sw_val into ctrl and pulses step.
// Optional macro HOLD_REPEAT_EN: while the key stays pressed, an extra press
// event is issued every REPEAT_CYCLES cycles.
// -----------------------------------------------------------------------------
module dp_input_iface
   import dp_iface_pkg::*;
#(
   parameter int DATA_W          = 16,
   parameter int SW_W            = 8,
   parameter int CTRL_W          = 9,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   dp_input_iface_if.slave bus
);

   localparam int NCHUNK = DATA_W / SW_W;
   localparam int CIDX_W = chunk_idx_w(NCHUNK);

   if ((DATA_W % SW_W) != 0 || CTRL_W < SW_W || DEBOUNCE_CYCLES < 2 ||
       REPEAT_CYCLES < 2) begin : g_bad_cfg
      $error("dp_input_iface: unsupported parameter combination");
   end

   logic              press_evt;
   logic              key_level;
   logic              evt;
   logic              mode_sync_p0;
   logic              mode_sync_p1;
   logic              mode_sync_p2;
   logic              mode_rise;
   logic [CIDX_W-1:0] cidx_eff;
   logic [DATA_W-1:0] dp_r;
   logic [CTRL_W-1:0] ctrl_r;
   logic              step_r;
   logic [CIDX_W-1:0] cidx_r;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n     (bus.key_n),
      .press_evt (press_evt),
      .key_level (key_level)
   );

   // Entering data mode restarts loading at chunk 0, including for a press
   // landing in the very same cycle.
   assign mode_rise = mode_sync_p1 & ~mode_sync_p2;
   assign cidx_eff  = mode_rise ? '0 : cidx_r;

`ifdef HOLD_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYCLES);

   logic             mode_chg;
   logic             rep_fire;
   logic [REP_W-1:0] rep_cnt;

   assign mode_chg = mode_sync_p1 ^ mode_sync_p2;
   assign rep_fire = ~key_level && ~press_evt && ~mode_chg &&
                     (rep_cnt == REP_W'(REPEAT_CYCLES - 1));

   // Restarts on the press itself so the first repeat lands REPEAT_CYCLES
   // cycles after the original event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt <= '0;
      end else if (key_level || mode_chg || press_evt || rep_fire) begin
         rep_cnt <= '0;
      end else begin
         rep_cnt <= rep_cnt + REP_W'(1);
      end
   end

   assign evt = press_evt | rep_fire;
`else
   // press_evt is only ever raised while the debounced level reads pressed
   assign evt = press_evt & ~key_level;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_sync_p0 <= MODE_CTRL;
         mode_sync_p1 <= MODE_CTRL;
         mode_sync_p2 <= MODE_CTRL;
         dp_r         <= '0;
         ctrl_r       <= '0;
         step_r       <= 1'b0;
         cidx_r       <= '0;
      end else begin
         // sync stage boundary: p1 is the usable mode, p2 its previous value
         mode_sync_p0 <= bus.sw_mode;
         mode_sync_p1 <= mode_sync_p0;
         mode_sync_p2 <= mode_sync_p1;
         step_r       <= 1'b0;
         if (mode_rise) begin
            cidx_r <= '0;
         end
         if (evt) begin
            if (mode_sync_p1 == MODE_DATA) begin
               for (int i = 0; i < NCHUNK; i++) begin
                  if (cidx_eff == CIDX_W'(i)) begin
                     dp_r[i*SW_W +: SW_W] <= bus.sw_val[SW_W-1:0];
                  end
               end
               cidx_r <= (cidx_eff == CIDX_W'(NCHUNK - 1)) ? '0
                                                           : cidx_eff + CIDX_W'(1);
            end else begin
               ctrl_r <= bus.sw_val;
               step_r <= 1'b1;
            end
         end
      end
   end

   assign bus.datapath_in = dp_r;
   assign bus.ctrl        = ctrl_r;
   assign bus.step        = step_r;
   assign bus.chunk_idx   = cidx_r;
   assign bus.led         = (mode_sync_p1 == MODE_DATA) ? ctrl_r
                                                        : CTRL_W'(dp_r[SW_W-1:0]);

endmodule

// File: tb/tb_dp_input_iface.sv
module tb_dp_input_iface;
   import dp_iface_pkg::*;

   localparam int DATA_W = 16;
   localparam int SW_W   = 8;
   localparam int CTRL_W = 9;
   localparam int DEB    = 4;
   localparam int REP    = 10;
`ifdef HOLD_REPEAT_EN
   localparam int NREP = 4;
`else
   localparam int NREP = 1;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   dp_input_iface_if #(.DATA_W(DATA_W), .SW_W(SW_W), .CTRL_W(CTRL_W)) bus ();

   dp_input_iface #(
      .DATA_W          (DATA_W),
      .SW_W            (SW_W),
      .CTRL_W          (CTRL_W),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_CYCLES   (REP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_step;
      logic [15:0] dp;
      logic [8:0]  ctrl;
      int          cidx;
      logic [8:0]  led;
   } exp_t;

   exp_t exp_q[$];
   int   step_cyc[$];

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_mode(input bit m);
      bus.sw_mode = m;
      tick(4);
   endtask

   // Called just after a rising edge; pushes n_evt expected events, holds the
   // key low for 'hold' sampled edges, then idles long enough for release.
   task automatic press(input logic [8:0] val, input int hold, input int n_evt,
                        input bit is_step, input logic [15:0] e_dp,
                        input logic [8:0] e_ctrl, input int e_cidx,
                        input logic [8:0] e_led, output int lat);
      exp_t e;
      e.is_step = is_step;
      e.dp      = e_dp;
      e.ctrl    = e_ctrl;
      e.cidx    = e_cidx;
      e.led     = e_led;
      for (int k = 0; k < n_evt; k++) exp_q.push_back(e);
      lat = -1;
      bus.sw_val = val;
      bus.key_n  = 1'b0;
      for (int i = 1; i <= hold + 14; i++) begin
         @(posedge clk);
         #1;
         if (bus.step && lat < 0) lat = i;
         if (i == hold) bus.key_n = 1'b1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dp"},   int'(bus.datapath_in), 0);
      check({tag, "_ctrl"}, int'(bus.ctrl), 0);
      check({tag, "_step"}, int'(bus.step), 0);
      check({tag, "_cidx"}, int'(bus.chunk_idx), 0);
      check({tag, "_led"},  int'(bus.led), 0);
   endtask

   // Monitor: any step pulse, data change or chunk advance is an output event.
   initial begin : monitor
      logic [15:0] prev_dp;
      int          prev_c;
      int          cyc;
      bit          ev;
      exp_t        e;
      prev_dp = '0;
      prev_c  = 0;
      cyc     = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            ev = bus.step || (bus.datapath_in != prev_dp) ||
                 ((int'(bus.chunk_idx) != prev_c) && (bus.chunk_idx != 0));
            if (ev) begin
               n_checks++;
               if (bus.step) step_cyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL unexpected_event: step=%0d dp=0x%0h ctrl=0x%0h cidx=%0d, required no event",
                           bus.step, bus.datapath_in, bus.ctrl, bus.chunk_idx);
               end else begin
                  e = exp_q.pop_front();
                  if (bus.step != e.is_step || bus.datapath_in != e.dp ||
                      bus.ctrl != e.ctrl || int'(bus.chunk_idx) != e.cidx ||
                      bus.led != e.led) begin
                     n_errors++;
                     $display("FAIL event: got step=%0d dp=0x%0h ctrl=0x%0h cidx=%0d led=0x%0h, required step=%0d dp=0x%0h ctrl=0x%0h cidx=%0d led=0x%0h",
                              bus.step, bus.datapath_in, bus.ctrl, bus.chunk_idx, bus.led,
                              e.is_step, e.dp, e.ctrl, e.cidx, e.led);
                  end
               end
            end
         end
         prev_dp = bus.datapath_in;
         prev_c  = int'(bus.chunk_idx);
      end
   end

   initial begin : stimulus
      int   lat;
      exp_t e;
      bus.key_n   = 1'b1;
      bus.sw_mode = 1'b0;
      bus.sw_val  = '0;

      // asynchronous reset, asserted between clock edges
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick(3);

      // chunked load: 0x0AB then 0x0CD
      set_mode(1'b1);
      press(9'h0AB, 6, 1, 1'b0, 16'h00AB, 9'h000, 1, 9'h000, lat);
      check("cidx_after_first", int'(bus.chunk_idx), 1);
      press(9'h0CD, 6, 1, 1'b0, 16'hCDAB, 9'h000, 0, 9'h000, lat);
      check("dp_loaded", int'(bus.datapath_in), 16'hCDAB);
      check("cidx_wrapped", int'(bus.chunk_idx), 0);

      // control step
      set_mode(1'b0);
      press(9'h1A5, 6, 1, 1'b1, 16'hCDAB, 9'h1A5, 0, 9'h0AB, lat);
      check("step_latency", lat, 7);
      check("ctrl_latched", int'(bus.ctrl), 9'h1A5);
      check("led_ctrl_mode", int'(bus.led), 9'h0AB);

      // bounce rejection, then a 5-cycle stable press
      repeat (3) begin
         bus.key_n = 1'b0;
         tick(3);
         bus.key_n = 1'b1;
         tick(6);
      end
      check("bounce_ctrl_held", int'(bus.ctrl), 9'h1A5);
      press(9'h055, 5, 1, 1'b1, 16'hCDAB, 9'h055, 0, 9'h0AB, lat);
      check("bounce_press_latency", lat, 7);

      // mode-entry clear
      set_mode(1'b1);
      press(9'h011, 6, 1, 1'b0, 16'hCD11, 9'h055, 1, 9'h055, lat);
      set_mode(1'b0);
      check("cidx_kept_on_exit", int'(bus.chunk_idx), 1);
      check("led_shows_data", int'(bus.led), 9'h011);
      set_mode(1'b1);
      check("cidx_cleared_on_entry", int'(bus.chunk_idx), 0);
      check("led_shows_ctrl", int'(bus.led), 9'h055);
      press(9'h077, 6, 1, 1'b0, 16'hCD77, 9'h055, 1, 9'h055, lat);
      check("dp_after_entry", int'(bus.datapath_in), 16'hCD77);
      check("cidx_after_entry", int'(bus.chunk_idx), 1);

      // mode entry landing in the same cycle as the press event
      set_mode(1'b0);
      check("cidx_before_coincident", int'(bus.chunk_idx), 1);
      e.is_step = 1'b0;
      e.dp      = 16'hCD99;
      e.ctrl    = 9'h055;
      e.cidx    = 1;
      e.led     = 9'h055;
      exp_q.push_back(e);
      bus.sw_val = 9'h099;
      bus.key_n  = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (i == 4) bus.sw_mode = 1'b1;
         if (i == 6) bus.key_n = 1'b1;
      end
      check("dp_coincident", int'(bus.datapath_in), 16'hCD99);
      check("cidx_coincident", int'(bus.chunk_idx), 1);

      // long hold in control mode
      set_mode(1'b0);
      step_cyc.delete();
      press(9'h1C3, 35, NREP, 1'b1, 16'hCD99, 9'h1C3, 1, 9'h099, lat);
      tick(20);
      check("hold_step_count", step_cyc.size(), NREP);
`ifdef HOLD_REPEAT_EN
      for (int k = 1; k < step_cyc.size(); k++)
         check("repeat_spacing", step_cyc[k] - step_cyc[k-1], REP);
`endif

      // reset in the middle of a debounce aborts the press
      bus.sw_val = 9'h1FF;
      bus.key_n  = 1'b0;
      tick(3);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      bus.key_n = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick(15);
      check_all_zero("after_midreset");

      tick(3);
      check("pending_events", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
